// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, config field positions and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DIV_LSB  = 0;
  localparam int DIV_MSB  = 15;
  localparam int PAR_LSB  = 16;
  localparam int STOP_BIT = 18;

  localparam logic [31:0] CONF_RESET = 32'h0000_0060;
  localparam int          MIN_DIV    = 2;

  // A divisor below MIN_DIV cannot produce a full bit period, so it is raised.
  function automatic logic [15:0] clamp_div(input logic [15:0] raw);
    return (raw < 16'(MIN_DIV)) ? 16'(MIN_DIV) : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Loadable down-counter; tick is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmit framer; config is shadowed once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CONFIG_WIDTH-1:0] conf_in,
  input  logic                    tx_req,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_ack,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    txd
);

  localparam logic [2:0] c_last_bit = 3'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_next_state;
  logic [15:0]           r_div;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_two_stop;
  logic                  r_stop_cnt;
  logic [2:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_ack;

  logic [15:0]           w_conf_div;
  logic [1:0]            w_conf_par;
  logic                  w_start;
  logic                  w_tick;
  logic                  w_load;
  logic [15:0]           w_load_val;
  logic                  w_last_stop;

  assign w_conf_div = clamp_div(conf_in[DIV_MSB:DIV_LSB]);
  assign w_conf_par = conf_in[PAR_LSB+1:PAR_LSB];
  assign w_start    = (r_state == IDLE) && tx_req;
  assign w_last_stop = !r_two_stop || r_stop_cnt;

  if (CONFIG_WIDTH > STOP_BIT + 1) begin : g_unused_conf
    logic w_unused_conf_hi;
    assign w_unused_conf_hi = ^conf_in[CONFIG_WIDTH-1:STOP_BIT+1];
  end

  // While idle the counter tracks the live config so START begins fully loaded.
  assign w_load     = (r_state == IDLE) || w_tick;
  assign w_load_val = (r_state == IDLE) ? (w_conf_div - 16'd1) : (r_div - 16'd1);

  uart_baud_cnt #(
    .WIDTH (16)
  ) u_baud_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    txd          = 1'b1;
    tx_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_req) w_next_state = START;
      end
      START: begin
        txd = 1'b0;
        if (w_tick) w_next_state = DATA;
      end
      DATA: begin
        txd = r_shift[0];
        if (w_tick && (r_bit_cnt == c_last_bit)) begin
          w_next_state = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        txd = r_par_bit;
        if (w_tick) w_next_state = STOP;
      end
      STOP: begin
        if (w_tick && w_last_stop) begin
          tx_done      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div      <= clamp_div(CONF_RESET[DIV_MSB:DIV_LSB]);
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= CONF_RESET[STOP_BIT];
      r_stop_cnt <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= w_start;
      if (w_start) begin
        r_div      <= w_conf_div;
        r_par_en   <= (w_conf_par == PAR_EVEN) || (w_conf_par == PAR_ODD);
        r_par_bit  <= (w_conf_par == PAR_ODD) ? ~(^tx_data) : (^tx_data);
        r_two_stop <= conf_in[STOP_BIT];
        r_shift    <= tx_data;
        r_bit_cnt  <= 3'd0;
        r_stop_cnt <= 1'b0;
      end
      if ((r_state == DATA) && w_tick) begin
        r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == STOP) && w_tick) begin
        r_stop_cnt <= ~r_stop_cnt;
      end
    end
  end

  assign tx_ack  = r_ack;
  assign tx_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Directed self-checking bench for uart_tx_frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  logic        clock;
  logic        reset;
  logic [31:0] conf_in;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic        tx_busy;
  logic        tx_done;
  logic        txd;

  int errors = 0;
  int checks = 0;

  uart_tx_frame #(
    .CONFIG_WIDTH (32),
    .DATA_WIDTH   (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .conf_in (conf_in),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_ack  (tx_ack),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .txd     (txd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Request one frame and check it cycle by cycle from the tx_ack cycle onward.
  task automatic run_frame(input string tag, input logic [7:0] data,
                           input logic [31:0] conf, input int div, input int pmode,
                           input int nstop, input bit keep_req,
                           input logic [7:0] next_data, input int chg_cycle,
                           input logic [31:0] chg_conf);
    logic [11:0] exp_bits;
    int          nbits;
    int          frame;
    int          wait_cnt;
    int          done_cnt;
    int          done_at;
    int          busy_err;
    int          ack_extra;
    int          bit_err [12];

    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = data[i];
    nbits = 9;
    if (pmode == 1) begin
      exp_bits[nbits] = ^data;
      nbits++;
    end else if (pmode == 2) begin
      exp_bits[nbits] = ~(^data);
      nbits++;
    end
    nbits += nstop;
    frame = div * nbits;
    for (int i = 0; i < 12; i++) bit_err[i] = 0;

    conf_in = conf;
    tx_data = data;
    tx_req  = 1'b1;
    wait_cnt = 0;
    do begin
      step();
      wait_cnt++;
    end while (!tx_ack && wait_cnt < 20);
    check({tag, " ack_latency"}, wait_cnt, 1);

    done_cnt  = 0;
    done_at   = -1;
    busy_err  = 0;
    ack_extra = 0;
    for (int c = 0; c < frame; c++) begin
      if (c == 0) begin
        if (keep_req) tx_data = next_data;
        else          tx_req  = 1'b0;
      end
      if (c == chg_cycle) conf_in = chg_conf;
      if (txd !== exp_bits[c / div]) bit_err[c / div]++;
      if (tx_busy !== 1'b1) busy_err++;
      if (c > 0 && tx_ack !== 1'b0) ack_extra++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      step();
    end

    for (int b = 0; b < nbits; b++) begin
      check($sformatf("%s bit%0d_txd_errs", tag, b), bit_err[b], 0);
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_at, frame - 1);
    check({tag, " busy_drop"}, busy_err, 0);
    check({tag, " ack_extra"}, ack_extra, 0);
    check({tag, " idle_txd"}, int'(txd), 1);
    check({tag, " idle_busy"}, int'(tx_busy), 0);
  endtask

  initial begin
    reset   = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    conf_in = 32'h0000_0060;

    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset%0d txd", i), int'(txd), 1);
      check($sformatf("reset%0d busy", i), int'(tx_busy), 0);
      check($sformatf("reset%0d ack", i), int'(tx_ack), 0);
      check($sformatf("reset%0d done", i), int'(tx_done), 0);
    end
    reset = 1'b1;
    step();

    run_frame("default_a5", 8'hA5, 32'h0000_0060, 96, 0, 1, 0, 8'h00, -1, 32'h0);
    run_frame("even_07",    8'h07, 32'h0001_0010, 16, 1, 1, 0, 8'h00, -1, 32'h0);
    run_frame("odd_07",     8'h07, 32'h0002_0010, 16, 2, 1, 0, 8'h00, -1, 32'h0);
    run_frame("rsvd_par",   8'h07, 32'h0003_0010, 16, 0, 1, 0, 8'h00, -1, 32'h0);
    run_frame("two_stop",   8'hFF, 32'h0004_0004,  4, 0, 2, 0, 8'h00, -1, 32'h0);
    run_frame("clamp0",     8'h55, 32'h0000_0000,  2, 0, 1, 0, 8'h00, -1, 32'h0);
    run_frame("clamp1",     8'h55, 32'h0000_0001,  2, 0, 1, 0, 8'h00, -1, 32'h0);

    // Held request: second byte follows after exactly one idle cycle.
    run_frame("b2b_first",  8'h12, 32'h0000_0010, 16, 0, 1, 1, 8'h34, 50, 32'h0000_0020);
    run_frame("b2b_second", 8'h34, 32'h0000_0020, 32, 0, 1, 0, 8'h00, -1, 32'h0);

    // Abort during data bit 3 of 0x3C at div 16.
    conf_in = 32'h0000_0010;
    tx_data = 8'h3C;
    tx_req  = 1'b1;
    begin
      int wait_cnt;
      int early_done;
      wait_cnt = 0;
      do begin
        step();
        wait_cnt++;
      end while (!tx_ack && wait_cnt < 20);
      check("abort ack_latency", wait_cnt, 1);
      tx_req = 1'b0;
      early_done = 0;
      for (int c = 0; c < 69; c++) begin
        step();
        if (tx_done === 1'b1) early_done++;
      end
      check("abort pre_done", early_done, 0);
      check("abort bit3_txd", int'(txd), 1);
      check("abort busy_before", int'(tx_busy), 1);
    end
    reset = 1'b0;
    step();
    check("abort txd", int'(txd), 1);
    check("abort busy", int'(tx_busy), 0);
    check("abort done", int'(tx_done), 0);
    step();
    check("abort done2", int'(tx_done), 0);
    check("abort ack", int'(tx_ack), 0);
    reset = 1'b1;
    step();
    run_frame("after_abort", 8'h3C, 32'h0000_0010, 16, 0, 1, 0, 8'h00, -1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer that sits directly downstream of the UART configuration register.
- Consumes the 32-bit config word (baud divisor, parity, stop bits) and byte requests from the host side.
- Serialises each byte onto txd: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Config is sampled once per frame, so a config update mid-frame never corrupts a frame in flight.

Parameters:
CONFIG_WIDTH, 32, width of the conf_in word (bits above 18 ignored)
DATA_WIDTH, 8, payload bits per frame (fixed at 8 for this revision)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low; 0 = reset
conf_in  in  CONFIG_WIDTH  config word from the config register: [15:0] clocks per bit, [17:16] parity mode, [18] stop bits
tx_req  in  1  byte request; held high with tx_data stable until tx_ack
tx_data  in  DATA_WIDTH  byte to send
tx_ack  out  1  one-cycle pulse: tx_data latched, frame started
tx_busy  out  1  high from START entry until STOP completes
tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit
txd  out  1  serial line, idle high

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, txd=1, tx_ack=0, tx_busy=0, tx_done=0, counters=0. Reset mid-frame aborts immediately; txd returns high on the next edge, with no partial stop bit.
- Config decode, latched into shadow registers on the IDLE->START transition:
  - div = conf_in[15:0]; values 0 and 1 are clamped to 2.
  - parity mode: 00 none, 01 even, 10 odd, 11 none (reserved).
  - stop bits: conf_in[18] = 0 gives 1 stop bit; 1 gives 2 stop bits.
  - Reset-default config 0x60 gives div 96, no parity, 1 stop bit.
- States:
  - IDLE: txd=1. If tx_req=1, go to START next edge; latch tx_data and config; tx_ack=1 for exactly that one cycle; tx_busy=1.
  - START: txd=0 for div cycles.
  - DATA: txd=shift[0]; shift right every div cycles; 8 bits, LSB first.
  - PARITY: entered only if parity enabled; txd = XOR of data bits for even, inverted for odd; lasts div cycles.
  - STOP: txd=1 for div cycles per stop bit. tx_done pulses in the final cycle. Next state is IDLE.
- Baud counter: loads div-1 on every state/bit entry and counts down; the bit ends when the counter reaches 0. Each bit is exactly div clocks.
- Bit counter: 3 bits, counts 0..7 in DATA; wraps to 0 on exit.
- Latency: tx_req seen high in IDLE at edge N gives tx_ack and txd=0 from edge N+1.
- Frame length = div*(1+8+P+S) clocks, where P is 0 or 1 and S is 1 or 2.
- Back-to-back: after STOP, at least one IDLE cycle (txd=1). A tx_req still high then starts the next frame, giving a 1-clock inter-frame gap.
- tx_req is ignored while tx_busy=1. The requester must present new data or drop tx_req after tx_ack; a held tx_req resends tx_data.
- conf_in changes while busy take effect at the next frame only.
- tx_ack and tx_done never assert in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - parity-mode constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
  - config field bit positions (DIV_LSB=0, DIV_MSB=15, PAR_LSB=16, STOP_BIT=18)
  - CONF_RESET=32'h60, MIN_DIV=2
- One natural sub-module: uart_baud_cnt, a loadable down-counter with a tick-at-zero output. It is reusable by the future receiver.

Test Plan:
- Reset default: reset low 3 cycles, then send 0xA5 with conf_in=0x60 -> frame 960 clocks; txd pattern 0,1,0,1,0,0,1,0,1,1, each held 96 clocks; tx_done at clock 960 after tx_ack.
- Even parity: conf_in=0x00010010 (div 16), send 0x07 -> parity bit=1, frame 176 clocks; odd mode (0x00020010) -> parity bit=0.
- Two stop bits: conf_in=0x00040004, send 0xFF -> txd high for 8 clocks after data; frame 44 clocks.
- Divisor clamp: conf_in=0x0 and 0x1, send 0x55 -> each bit lasts exactly 2 clocks, frame 20 clocks.
- Back-to-back plus mid-frame config change: hold tx_req across two bytes, 0x12 then 0x34 (0x34 presented after the first tx_ack); switch conf_in from 0x10 to 0x20 mid-frame -> first frame 160 clocks at div 16, 1-clock gap, second frame 320 clocks at div 32.
- Reset mid-frame: assert reset low during DATA bit 3 -> txd=1, tx_busy=0 on the next edge; no tx_done; next request produces a clean full frame.
